basilisk_writeback_arbiter: RTL

- Shares the single Basilisk vector-register-file write port between the functional-unit result streams: add, mult/macc, divide, sqrt, convert and memory-load.
- Arbitration is round-robin with a one-entry registered output stage.
- Optional burst lock keeps a vector instruction's offset beats contiguous, so a destination register is written in offset order without interleaving.
- Sits between the unit output normalisers/rounders and the vector register file writeback.

---
 rtl/basilisk_pkg.sv | 40 ++++
 rtl/basilisk_writeback_arbiter_if.sv | 29 ++
 rtl/basilisk_round_robin_select.sv | 31 +++
 rtl/basilisk_writeback_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/basilisk_pkg.sv
// Shared Basilisk types and constants: writeback result beat layout, offset geometry,
// writeback arbiter state encoding and the fixed result-stream order.
package basilisk_pkg;

  localparam int unsigned BASILISK_VECTOR_WIDTH   = 64;
  localparam int unsigned BASILISK_COMPUTE_WIDTH  = 32;
  localparam int unsigned BASILISK_OFFSET_COUNT   = BASILISK_VECTOR_WIDTH / BASILISK_COMPUTE_WIDTH;
  localparam int unsigned BASILISK_OFFSET_WIDTH   =
      (BASILISK_OFFSET_COUNT > 1) ? $clog2(BASILISK_OFFSET_COUNT) : 1;
  localparam int unsigned BASILISK_REG_ADDR_WIDTH = 5;

  // Writeback requester order; lower index wins first after reset.
  localparam int unsigned BASILISK_WB_REQ_ADD     = 0;
  localparam int unsigned BASILISK_WB_REQ_MULT    = 1;
  localparam int unsigned BASILISK_WB_REQ_DIVIDE  = 2;
  localparam int unsigned BASILISK_WB_REQ_SQRT    = 3;
  localparam int unsigned BASILISK_WB_REQ_CONVERT = 4;
  localparam int unsigned BASILISK_WB_REQ_MEMORY  = 5;

  typedef enum logic {
    BASILISK_WB_ARB_IDLE,
    BASILISK_WB_ARB_LOCKED
  } basilisk_writeback_arb_state_t;

  typedef struct packed {
    logic [BASILISK_COMPUTE_WIDTH-1:0]  data;
    logic [BASILISK_REG_ADDR_WIDTH-1:0] dest_reg_addr;
    logic [BASILISK_OFFSET_WIDTH-1:0]   dest_offset_addr;
  } basilisk_writeback_result_t;

  function automatic int unsigned basilisk_onehot_index(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/basilisk_writeback_arbiter_if.sv
// Writeback arbiter bus: per-requester result streams in, one register-file write port out.
interface basilisk_writeback_arbiter_if
  import basilisk_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 6
);
  localparam int unsigned W     = $bits(basilisk_writeback_result_t);
  localparam int unsigned SRC_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [NUM_REQUESTERS-1:0]   req_valid;
  logic [NUM_REQUESTERS-1:0]   req_ready;
  logic [NUM_REQUESTERS*W-1:0] req_data;
  logic                        result_valid;
  logic                        result_ready;
  logic [W-1:0]                result_data;
  logic [SRC_W-1:0]            result_source;
  logic                        protocol_error;

  modport master (
    output req_valid, req_data, result_ready,
    input  req_ready, result_valid, result_data, result_source, protocol_error
  );

  modport slave (
    input  req_valid, req_data, result_ready,
    output req_ready, result_valid, result_data, result_source, protocol_error
  );

endinterface

// File: rtl/basilisk_round_robin_select.sv
// Combinational round-robin picker: first eligible request after i_last, wrapping.
module basilisk_round_robin_select #(
  parameter int unsigned NUM_REQUESTERS = 6,
  localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic [NUM_REQUESTERS-1:0] i_req,
  input  logic [IDX_W-1:0]          i_last,
  input  logic [NUM_REQUESTERS-1:0] i_mask,
  output logic [NUM_REQUESTERS-1:0] o_grant
);

  logic [NUM_REQUESTERS-1:0] w_eligible;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_found;

  assign w_eligible = i_req & i_mask;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
      w_idx = IDX_W'((32'(i_last) + k) % NUM_REQUESTERS);
      if (!w_found && w_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/basilisk_writeback_arbiter.sv
// Round-robin arbiter for the vector register file write port with a one-entry output stage
// and optional burst lock that keeps a destination's offset beats contiguous.
module basilisk_writeback_arbiter
  import basilisk_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 6,
  parameter bit          BURST_LOCK     = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  basilisk_writeback_arbiter_if.slave bus
);

  localparam int unsigned W     = $bits(basilisk_writeback_result_t);
  localparam int unsigned SRC_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int unsigned OFF_W = BASILISK_OFFSET_WIDTH;
  localparam bit          LOCK_EN = BURST_LOCK && (BASILISK_OFFSET_COUNT > 1);
  localparam logic [OFF_W-1:0] LAST_OFFSET = OFF_W'(BASILISK_OFFSET_COUNT - 1);

  basilisk_writeback_arb_state_t r_state;
  logic [SRC_W-1:0]              r_last_grant;
  logic [SRC_W-1:0]              r_lock_owner;
  logic [OFF_W-1:0]              r_expected_offset;
  logic                          r_result_valid;
  basilisk_writeback_result_t    r_result_data;
  logic [SRC_W-1:0]              r_result_source;
  logic                          r_protocol_error;

  logic [NUM_REQUESTERS-1:0]     w_mask;
  logic [NUM_REQUESTERS-1:0]     w_grant;
  logic [NUM_REQUESTERS-1:0]     w_req_ready;
  logic                          w_accept_en;
  logic                          w_xfer;
  logic [SRC_W-1:0]              w_grant_idx;
  basilisk_writeback_result_t    w_beat;

  always_comb begin
    w_mask = '1;
    if (r_state == BASILISK_WB_ARB_LOCKED) w_mask = NUM_REQUESTERS'(1) << r_lock_owner;
  end

  basilisk_round_robin_select #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_select (
    .i_req  (bus.req_valid),
    .i_last (r_last_grant),
    .i_mask (w_mask),
    .o_grant(w_grant)
  );

  assign w_accept_en = !r_result_valid || bus.result_ready;
  assign w_req_ready = (rst && w_accept_en) ? w_grant : '0;
  assign w_xfer      = |(w_req_ready & bus.req_valid);
  assign w_grant_idx = SRC_W'(basilisk_onehot_index(32'(w_grant)));
  assign w_beat      = basilisk_writeback_result_t'(bus.req_data[w_grant_idx*W +: W]);

  assign bus.req_ready      = w_req_ready;
  assign bus.result_valid   = r_result_valid;
  assign bus.result_data    = r_result_data;
  assign bus.result_source  = r_result_source;
  assign bus.protocol_error = r_protocol_error;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= BASILISK_WB_ARB_IDLE;
      r_last_grant      <= SRC_W'(NUM_REQUESTERS - 1);
      r_lock_owner      <= '0;
      r_expected_offset <= '0;
      r_result_valid    <= 1'b0;
      r_result_data     <= '0;
      r_result_source   <= '0;
      r_protocol_error  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_result_valid  <= 1'b1;
        r_result_data   <= w_beat;
        r_result_source <= w_grant_idx;
        r_last_grant    <= w_grant_idx;
      end else if (r_result_valid && bus.result_ready) begin
        r_result_valid  <= 1'b0;
      end

      // Out-of-order offsets are flagged but still forwarded so no beat is lost.
      if (LOCK_EN && w_xfer) begin
        case (r_state)
          BASILISK_WB_ARB_IDLE: begin
            if (w_beat.dest_offset_addr == '0) begin
              r_state           <= BASILISK_WB_ARB_LOCKED;
              r_lock_owner      <= w_grant_idx;
              r_expected_offset <= OFF_W'(1);
            end else begin
              r_protocol_error  <= 1'b1;
            end
          end
          BASILISK_WB_ARB_LOCKED: begin
            if (w_beat.dest_offset_addr == r_expected_offset) begin
              if (w_beat.dest_offset_addr == LAST_OFFSET) begin
                r_state           <= BASILISK_WB_ARB_IDLE;
                r_expected_offset <= '0;
              end else begin
                r_expected_offset <= r_expected_offset + OFF_W'(1);
              end
            end else begin
              r_protocol_error  <= 1'b1;
              r_state           <= BASILISK_WB_ARB_IDLE;
              r_expected_offset <= '0;
            end
          end
          default: begin
            r_state           <= BASILISK_WB_ARB_IDLE;
            r_expected_offset <= '0;
          end
        endcase
      end
    end
  end

endmodule
